// File: rtl/ca_stream_pkg.sv
// Shared stream definitions for the adapted-pixel path: pixel width, default
// raster geometry and the beat layout shared with the display writer.
package ca_stream_pkg;

  localparam int RGB_W        = 24;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_beat_t;

  // Marker-only view; keeps the framer usable when DATA_W differs from RGB_W.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_mark_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; occupancy is kept as a separate
// counter so full/empty never depend on pointer comparisons.
module sync_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          we;
  logic          re;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign we    = wr_en && !full;
  assign re    = rd_en && !empty;
  assign level = count;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      case ({we, re})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adapted_pixel_framer.sv
// Buffers adapted pixels, tags them with raster markers at push time and
// counts frames as their last pixel leaves toward the display writer.
module adapted_pixel_framer
  import ca_stream_pkg::*;
#(
  parameter int DATA_W   = RGB_W,
  parameter int DEPTH    = 16,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_rgb_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   frame_restart,
  output logic [DATA_W-1:0]      out_rgb_data,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [15:0]            frame_count
);

  localparam int XW = cnt_w(H_ACTIVE);
  localparam int YW = cnt_w(V_ACTIVE);
  localparam int MW = $bits(pix_mark_t);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0]        x, x_cur;
  logic [YW-1:0]        y, y_cur;
  pix_mark_t            mark_in, mark_out;
  logic [DATA_W-1:0]    head_rgb;
  logic [DATA_W+MW-1:0] fifo_rd;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;

  // A restart in the same cycle as a push places that pixel at (0,0).
  assign x_cur = frame_restart ? '0 : x;
  assign y_cur = frame_restart ? '0 : y;

  assign mark_in.sof = (x_cur == '0) && (y_cur == '0);
  assign mark_in.eol = (x_cur == X_LAST);
  assign mark_in.eof = (x_cur == X_LAST) && (y_cur == Y_LAST);

  assign in_ready  = !fifo_full && !rst;
  assign out_valid = !fifo_empty && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .W     (DATA_W + MW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({in_rgb_data, mark_in}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  assign {head_rgb, mark_out} = fifo_rd;
  assign out_rgb_data = out_valid ? head_rgb : '0;
  assign out_sof      = out_valid && mark_out.sof;
  assign out_eol      = out_valid && mark_out.eol;
  assign out_eof      = out_valid && mark_out.eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else begin
      if (push) begin
        if (mark_in.eol) begin
          x <= '0;
          y <= mark_in.eof ? '0 : y_cur + 1'b1;
        end else begin
          x <= x_cur + 1'b1;
          y <= y_cur;
        end
      end else if (frame_restart) begin
        x <= '0;
        y <= '0;
      end
      if (pop && mark_out.eof) frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adapted_pixel_framer.sv
// Scoreboard bench for adapted_pixel_framer using a 4x2 raster and 16-deep FIFO.
module tb_adapted_pixel_framer;
  import ca_stream_pkg::*;

  localparam int DEPTH = 16;
  localparam int H     = 4;
  localparam int V     = 2;

  logic        clk;
  logic        rst;
  logic [23:0] in_rgb_data;
  logic        in_valid;
  logic        in_ready;
  logic        frame_restart;
  logic [23:0] out_rgb_data;
  logic        out_sof, out_eol, out_eof;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fill_level;
  logic [15:0] frame_count;

  adapted_pixel_framer #(
    .DATA_W   (24),
    .DEPTH    (DEPTH),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_rgb_data   (in_rgb_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .frame_restart (frame_restart),
    .out_rgb_data  (out_rgb_data),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .out_eof       (out_eof),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fill_level    (fill_level),
    .frame_count   (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state, advanced at each falling edge for the coming rising edge.
  pix_beat_t sb[$];
  int lvl     = 0;
  int mx      = 0;
  int my      = 0;
  int mframe  = 0;
  int acc_cnt = 0;
  int max_lvl = 0;

  always @(negedge clk) begin
    pix_beat_t e;
    pix_beat_t h;
    bit do_push, do_pop;
    int ex, ey;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rgb", out_rgb_data, 0);
      chk("rst_marks", {out_sof, out_eol, out_eof}, 0);
      sb.delete();
      lvl = 0; mx = 0; my = 0; mframe = 0;
    end else begin
      chk("in_ready", in_ready, (lvl != DEPTH));
      chk("out_valid", out_valid, (lvl != 0));
      chk("fill_level", fill_level, lvl);
      chk("frame_count", frame_count, mframe);
      if (lvl != 0) begin
        h = sb[0];
        chk("head_rgb", out_rgb_data, h.rgb);
        chk("head_sof", out_sof, h.sof);
        chk("head_eol", out_eol, h.eol);
        chk("head_eof", out_eof, h.eof);
      end else begin
        chk("empty_rgb", out_rgb_data, 0);
        chk("empty_marks", {out_sof, out_eol, out_eof}, 0);
      end
      do_push = in_valid && (lvl < DEPTH);
      do_pop  = out_ready && (lvl > 0);
      if (do_pop) begin
        e = sb.pop_front();
        if (e.eof) mframe = (mframe + 1) & 16'hFFFF;
      end
      if (do_push) begin
        ex = frame_restart ? 0 : mx;
        ey = frame_restart ? 0 : my;
        e.rgb = in_rgb_data;
        e.sof = (ex == 0) && (ey == 0);
        e.eol = (ex == H - 1);
        e.eof = (ex == H - 1) && (ey == V - 1);
        sb.push_back(e);
        acc_cnt++;
        if (ex == H - 1) begin
          mx = 0;
          my = (ey == V - 1) ? 0 : ey + 1;
        end else begin
          mx = ex + 1;
          my = ey;
        end
      end else if (frame_restart) begin
        mx = 0; my = 0;
      end
      lvl = lvl + int'(do_push) - int'(do_pop);
      if (lvl > max_lvl) max_lvl = lvl;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input bit restart);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    in_rgb_data   = d;
    in_valid      = 1'b1;
    frame_restart = restart;
    tick();
    frame_restart = 1'b0;
    while (acc_cnt == start && n < 200) begin
      tick();
      n++;
    end
    if (acc_cnt == start) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (lvl != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", lvl, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    frame_restart = 1'b0; in_rgb_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Three pixels straight through with a ready sink
    max_lvl = 0;
    out_ready = 1'b1;
    send(24'hFF0000, 1'b0);
    send(24'h00FF00, 1'b0);
    send(24'h0000FF, 1'b0);
    drain();
    chk("t1_max_fill", max_lvl, 1);

    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Two full 4x2 frames
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(24'h000100 + 24'(i), 1'b0);
    drain();
    chk("t3_frames", frame_count, 2);

    // Fill to capacity against a stalled sink
    out_ready = 1'b0;
    start = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_rgb_data = 24'h000200 + 24'(i);
      tick();
    end
    chk("t2_accepted", acc_cnt - start, 16);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_fill", fill_level, 16);
    out_ready = 1'b1;
    tick();
    chk("t2_ready_back", in_ready, 1);
    chk("t2_fill_after_pop", fill_level, 15);
    drain();

    // Random valid/ready traffic
    start = acc_cnt;
    n = 0;
    while ((acc_cnt - start) < 1000 && n < 10000) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      in_rgb_data = 24'($urandom);
      tick();
      n++;
    end
    chk("rand_accepted", (acc_cnt - start) >= 1000, 1);
    drain();
    chk("rand_max_fill", max_lvl <= DEPTH, 1);

    // Restart alone, then restart coinciding with a push
    in_valid = 1'b0;
    frame_restart = 1'b1; tick(); frame_restart = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(24'h000300 + 24'(i), 1'b0);
    send(24'hABCDEF, 1'b1);
    send(24'h000310, 1'b0);
    send(24'h000311, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("t5_fill", fill_level, 8);
    drain();

    // Reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(24'h000400 + 24'(i), 1'b0);
    in_valid = 1'b0;
    tick();
    chk("t6_fill_before", fill_level, 6);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_fill", fill_level, 0);
    chk("t6_frames", frame_count, 0);
    out_ready = 1'b1;
    send(24'h123456, 1'b0);
    in_valid = 1'b0;
    chk("t6_first_sof", out_sof, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
